// File: rtl/dpbram_stream_reader_if.sv
// BRAM master port bundle plus the valid/ready output stream of the reader.
// The master modport is the reader side; the slave modport is the RAM/consumer side.
interface dpbram_stream_reader_if #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned RAM_DEPTH = 1000
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic [AW-1:0]     m_addr;
  logic              m_ce;
  logic              m_we;
  logic [DWIDTH-1:0] m_din;
  logic [DWIDTH-1:0] m_dout;
  logic [DWIDTH-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output m_addr, m_ce, m_we, m_din, o_data, o_valid,
    input  m_dout, i_ready
  );

  modport slave (
    input  m_addr, m_ce, m_we, m_din, o_data, o_valid,
    output m_dout, i_ready
  );
endinterface

// File: rtl/dpbram_stream_reader.sv
// Streams i_length consecutive BRAM words (wrapping at RAM_DEPTH-1) onto a valid/ready
// output through a 2-entry FIFO; never writes the RAM.
module dpbram_stream_reader #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned RAM_DEPTH = 1000,
  localparam int unsigned AW       = $clog2(RAM_DEPTH),
  localparam int unsigned LW       = $clog2(RAM_DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [LW-1:0] i_length,
  output logic          o_busy,
  output logic          o_done,
  dpbram_stream_reader_if.master io_bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  r_state;
  state_e                  w_state_d;
  logic [AW-1:0]           r_ptr;
  logic [AW-1:0]           w_ptr_inc;
  logic [LW-1:0]           r_remaining;
  logic                    r_inflight;
  logic [1:0][DWIDTH-1:0]  r_fifo;
  logic                    r_wr_idx;
  logic                    r_rd_idx;
  logic [1:0]              r_occ;
  logic [1:0]              w_occ_d;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_issue;

  assign w_pop  = (r_occ != 2'd0) & io_bus.i_ready;
  assign w_push = r_inflight;

  // Issue only if the FIFO can still absorb this read after the current pop; this makes
  // m_ce depend combinationally on i_ready so a full-rate stream keeps 1 word/cycle.
  assign w_issue = (r_state == StRun) && (r_remaining != '0) &&
                   (({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign w_occ_d   = r_occ + {1'b0, w_push} - {1'b0, w_pop};
  assign w_ptr_inc = (r_ptr == AW'(RAM_DEPTH - 1)) ? '0 : r_ptr + AW'(1);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_d = (i_length == '0) ? StDone : StRun;
      end
      StRun: begin
        if (w_issue && (r_remaining == LW'(1))) w_state_d = StDrain;
      end
      StDrain: begin
        // Last beat leaves the FIFO with nothing behind it.
        if (w_pop && !r_inflight && (r_occ == 2'd1)) w_state_d = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_fifo      <= '0;
      r_wr_idx    <= 1'b0;
      r_rd_idx    <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state    <= w_state_d;
      r_inflight <= w_issue;
      r_occ      <= w_occ_d;
      if ((r_state == StIdle) && i_start) begin
        r_ptr       <= i_base_addr;
        r_remaining <= i_length;
      end else if (w_issue) begin
        r_ptr       <= w_ptr_inc;
        r_remaining <= r_remaining - LW'(1);
      end
      if (w_push) begin
        r_fifo[r_wr_idx] <= io_bus.m_dout;
        r_wr_idx         <= ~r_wr_idx;
      end
      if (w_pop) r_rd_idx <= ~r_rd_idx;
    end
  end

  assign o_busy         = (r_state != StIdle);
  assign o_done         = (r_state == StDone);
  assign io_bus.m_addr  = r_ptr;
  assign io_bus.m_ce    = w_issue;
  assign io_bus.m_we    = 1'b0;
  assign io_bus.m_din   = '0;
  assign io_bus.o_valid = (r_occ != 2'd0);
  assign io_bus.o_data  = r_fifo[r_rd_idx];

endmodule

// File: tb/tb_dpbram_stream_reader.sv
// Scoreboard bench for dpbram_stream_reader: a BRAM model feeds the DUT, expected
// addresses and words are queued at start and compared as the DUT issues and streams.
module tb_dpbram_stream_reader;
  localparam int unsigned DWIDTH    = 16;
  localparam int unsigned RAM_DEPTH = 1000;
  localparam int unsigned AW        = $clog2(RAM_DEPTH);
  localparam int unsigned LW        = $clog2(RAM_DEPTH + 1);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [LW-1:0] i_length = '0;
  logic          o_busy;
  logic          o_done;

  dpbram_stream_reader_if #(.DWIDTH(DWIDTH), .RAM_DEPTH(RAM_DEPTH)) bus ();

  dpbram_stream_reader #(.DWIDTH(DWIDTH), .RAM_DEPTH(RAM_DEPTH)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_length    (i_length),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .io_bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [DWIDTH-1:0] mem [RAM_DEPTH];
  always @(posedge i_clk) if (bus.m_ce) bus.m_dout <= mem[bus.m_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, start_cyc = 0;
  int n_issue, n_pop, n_done, n_valid, busy_cycles;
  int first_ce, first_valid, last_valid, done_rel, busy_fall;
  int ready_mode = 0, stall_lo = 0, stall_hi = 0;
  logic [AW-1:0]     exp_addr [$];
  logic [DWIDTH-1:0] exp_data [$];
  logic              prev_stall = 1'b0;
  logic [DWIDTH-1:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_issue = 0; n_pop = 0; n_done = 0; n_valid = 0; busy_cycles = 0;
    first_ce = -1; first_valid = -1; last_valid = -1; done_rel = -1; busy_fall = -1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, {o_busy, o_done, bus.m_ce, bus.m_addr, bus.m_we, bus.m_din,
                   bus.o_valid, bus.o_data}, 64'd0);
  endtask

  // Start sampled at the next rising edge ("edge 0"); cycle k is the period after edge k-1.
  task automatic do_start(input int base, input int len);
    @(negedge i_clk); #1;
    clear_stats();
    start_cyc   = cyc;
    i_start     = 1'b1;
    i_base_addr = AW'(base);
    i_length    = LW'(len);
    for (int k = 0; k < len; k++) begin
      exp_addr.push_back(AW'((base + k) % RAM_DEPTH));
      exp_data.push_back(mem[(base + k) % RAM_DEPTH]);
    end
    @(negedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Start pulse the DUT must ignore; sampled at the next rising edge.
  task automatic ignored_start(input int base, input int len);
    i_start     = 1'b1;
    i_base_addr = AW'(base);
    i_length    = LW'(len);
    @(negedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge i_clk); #1;
      k++;
    end
    check_eq("done_timeout", (n_done == 0), 0);
    repeat (3) begin @(negedge i_clk); #1; end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge i_clk); #1;
    if (ready_mode == 0) bus.i_ready = 1'b1;
    else bus.i_ready = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 : ($urandom_range(3) != 0);
  end

  initial begin : monitor
    int rel;
    forever begin
      @(negedge i_clk);
      rel = cyc - start_cyc;
      if (!i_rst) begin
        check_eq("write_safety", {bus.m_we, bus.m_din}, 0);
        check_eq("ce_state", bus.m_ce & (!o_busy | o_done), 0);
        if (bus.m_ce) begin
          n_issue++;
          if (first_ce < 0) first_ce = rel;
          if (exp_addr.size() == 0) check_eq("extra_issue", 1, 0);
          else check_eq("addr", bus.m_addr, exp_addr.pop_front());
        end
        if (bus.o_valid) begin
          n_valid++;
          if (first_valid < 0) first_valid = rel;
          last_valid = rel;
        end
        if (bus.o_valid & bus.i_ready) begin
          n_pop++;
          if (exp_data.size() == 0) check_eq("extra_beat", 1, 0);
          else check_eq("data", bus.o_data, exp_data.pop_front());
        end
        check_eq("outstanding_le2", (n_issue - n_pop) > 2, 0);
        if (prev_stall) begin
          check_eq("stall_valid", bus.o_valid, 1);
          check_eq("stall_data", bus.o_data, prev_data);
        end
        prev_stall = bus.o_valid & !bus.i_ready;
        prev_data  = bus.o_data;
        if (o_done) begin n_done++; done_rel = rel; end
        if (o_busy) busy_cycles++;
        else if (busy_fall < 0 && busy_cycles > 0) busy_fall = rel;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = DWIDTH'(i * 37 + 16'h1234);
    mem[10] = 16'hAAAA; mem[11] = 16'hBBBB; mem[12] = 16'hCCCC; mem[13] = 16'hDDDD;
    bus.i_ready = 1'b1;
    clear_stats();
    #1;
    check_outputs_zero("reset_outputs");
    repeat (3) @(negedge i_clk);
    #1 i_rst = 1'b0;

    // Basic latency/throughput
    do_start(10, 4);
    wait_done(50);
    check_eq("basic_first_ce", first_ce, 1);
    check_eq("basic_issues", n_issue, 4);
    check_eq("basic_first_valid", first_valid, 3);
    check_eq("basic_last_valid", last_valid, 6);
    check_eq("basic_valid_cycles", n_valid, 4);
    check_eq("basic_done_cycle", done_rel, 7);
    check_eq("basic_done_count", n_done, 1);
    check_eq("basic_busy_cycles", busy_cycles, 7);
    check_eq("basic_busy_fall", busy_fall, 8);
    check_eq("basic_queue_empty", exp_data.size(), 0);

    // Address wrap
    do_start(998, 4);
    wait_done(50);
    check_eq("wrap_issues", n_issue, 4);
    check_eq("wrap_done_count", n_done, 1);
    check_eq("wrap_queue_empty", exp_data.size() + exp_addr.size(), 0);

    // Backpressure with a 10-cycle stall
    ready_mode = 1;
    stall_lo   = cyc + 8;
    stall_hi   = cyc + 18;
    do_start(300, 16);
    wait_done(400);
    ready_mode = 0;
    check_eq("bp_beats", n_pop, 16);
    check_eq("bp_done_count", n_done, 1);
    check_eq("bp_queue_empty", exp_data.size(), 0);

    // Zero length, plus a start in the DONE cycle that must be ignored
    do_start(5, 0);
    ignored_start(5, 3);
    repeat (6) begin @(negedge i_clk); #1; end
    check_eq("zero_done_cycle", done_rel, 1);
    check_eq("zero_busy_cycles", busy_cycles, 1);
    check_eq("zero_no_ce", n_issue, 0);
    check_eq("zero_done_count", n_done, 1);
    check_eq("zero_idle", o_busy, 0);

    // Start while busy is ignored
    do_start(100, 8);
    ignored_start(50, 5);
    wait_done(100);
    check_eq("busy_issues", n_issue, 8);
    check_eq("busy_beats", n_pop, 8);
    check_eq("busy_done_count", n_done, 1);
    check_eq("busy_queue_empty", exp_data.size() + exp_addr.size(), 0);

    // Length beyond RAM_DEPTH re-wraps
    do_start(997, 1003);
    wait_done(1200);
    check_eq("long_beats", n_pop, 1003);
    check_eq("long_done_count", n_done, 1);

    // Reset mid-transfer
    do_start(200, 8);
    begin
      int k = 0;
      while (n_pop < 3 && k < 50) begin @(negedge i_clk); #1; k++; end
    end
    check_eq("rst_pre_beats", n_pop, 3);
    i_rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid_outputs");
    exp_data.delete();
    exp_addr.delete();
    repeat (2) begin @(negedge i_clk); #1; end
    check_outputs_zero("rst_hold_outputs");
    i_rst = 1'b0;
    repeat (2) begin @(negedge i_clk); #1; end
    check_eq("rst_no_done", n_done, 0);
    check_eq("rst_stays_idle", {o_busy, bus.o_valid}, 0);
    do_start(0, 2);
    wait_done(50);
    check_eq("post_rst_beats", n_pop, 2);
    check_eq("post_rst_done", n_done, 1);
    check_eq("post_rst_queue_empty", exp_data.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
